// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-step multiply/divide unit owning HI/LO, with MTHI/MTLO writes and Operand2 select override.
// Result lands 33 edges after issue; decode is stalled while a HI/LO access meets an op in flight.
module hilo_muldiv_ctrl #(
  parameter logic [2:0] SEL_HI = 3'b001,
  parameter logic [2:0] SEL_LO = 3'b010,
  parameter int         ITER   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  input  logic        mf_hi,
  input  logic [2:0]  id_sel,
  output logic [2:0]  S,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        stall
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              signed_op;
  logic [31:0]       rs_abs;
  logic [31:0]       rt_abs;
  logic [32:0]       mul_sum;
  logic [32:0]       div_shift;
  logic              div_ge;
  logic [31:0]       div_rem;
  logic [63:0]       prod_fix;
  logic [31:0]       quo_fix;
  logic [31:0]       rem_fix;

  // MULT and DIV are the even codes; their odd neighbours are the unsigned forms.
  assign signed_op = ~op[0];
  assign rs_abs    = (signed_op && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign rt_abs    = (signed_op && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

  // acc holds {partial_hi, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_ge ? 32'(div_shift - {1'b0, opb_q}) : div_shift[31:0];

  assign prod_fix  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix   = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              acc_d    = {32'd0, rt_abs};
              opb_d    = rs_abs;
              neg_lo_d = signed_op & (rs_val[31] ^ rt_val[31]);
              neg_hi_d = signed_op & (rs_val[31] ^ rt_val[31]);
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (rt_val == 32'd0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                acc_d    = {32'd0, rs_abs};
                opb_d    = rt_abs;
                neg_lo_d = signed_op & (rs_val[31] ^ rt_val[31]);
                neg_hi_d = signed_op & rs_val[31];
                is_div_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_DIV;
              end
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end

      ST_DIV: begin
        acc_d = {div_rem, acc_q[30:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign HI          = hi_q;
  assign LO          = lo_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  // busy is already low in the done cycle, so an MF there sees the fresh HI/LO.
  assign stall       = busy & (start | mf_req);
  assign S           = mf_req ? (mf_hi ? SEL_HI : SEL_LO) : id_sel;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed ops with a result scoreboard popped on every done pulse.
module tb_hilo_muldiv_ctrl;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        mf_hi;
  logic [2:0]  id_sel;
  logic [2:0]  S;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        stall;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .mf_hi(mf_hi),
    .id_sel(id_sel), .S(S), .HI(HI), .LO(LO), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .stall(stall)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk("sb_hi", 64'(HI), 64'(e.hi));
        chk("sb_lo", 64'(LO), 64'(e.lo));
        chk("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int ebusy);
    int nb = 0;
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) nb++;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(ebusy));
    @(negedge clk);
    chk({nm, "_done_width"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int ebusy);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb.push_back(e);
    issue(o, a, b);
    wait_done(nm, ebusy);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  nb;
    bit  seen;
    reset = 1'b1; start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    mf_req = 1'b0; mf_hi = 1'b0; id_sel = 3'b011;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_s_idsel", 64'(S), 64'd3);

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    run_op("multu_same", MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0, 33);
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);

    issue(MTHI, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("mthi_hi", 64'(HI), 64'h12345678);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(MTLO, 32'h9ABCDEF0, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", 64'(LO), 64'h9ABCDEF0);
    chk("mtlo_hi_kept", 64'(HI), 64'h12345678);

    run_op("divu_zero", DIVU, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 0);
    chk("dbz_hi_kept", 64'(HI), 64'h12345678);
    chk("dbz_lo_kept", 64'(LO), 64'h9ABCDEF0);

    issue(3'b110, 32'h1, 32'h2);
    @(negedge clk);
    chk("op6_busy", 64'(busy), 64'd0);
    chk("op6_hi", 64'(HI), 64'h12345678);
    chk("op6_lo", 64'(LO), 64'h9ABCDEF0);

    // MF interlock around a MULT in flight: 5 * -2 = -10
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF6, dbz: 1'b0});
    issue(MULT, 32'd5, 32'hFFFFFFFE);
    repeat (3) @(posedge clk);
    #1 mf_req = 1'b1; mf_hi = 1'b1; id_sel = 3'b101;
    @(negedge clk);
    chk("mf_stall", 64'(stall), 64'd1);
    chk("mf_s_hi", 64'(S), 64'h1);
    #1 mf_req = 1'b0;
    #1;
    chk("nomf_s_idsel", 64'(S), 64'h5);
    chk("nomf_stall", 64'(stall), 64'd0);
    start = 1'b1; op = MTLO; rs_val = 32'hDEADBEEF;
    #1;
    chk("busy_start_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    mf_req = 1'b1; mf_hi = 1'b1;
    nb = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) nb++;
    end
    chk("mfdone_seen", 64'(seen), 64'd1);
    chk("mfdone_stall", 64'(stall), 64'd0);
    chk("mfdone_s", 64'(S), 64'h1);
    chk("mfdone_hi", 64'(HI), 64'hFFFFFFFF);
    chk("mfdone_lo", 64'(LO), 64'hFFFFFFF6);
    #1 mf_req = 1'b0;
    @(negedge clk);
    chk("mfdone_width", 64'(done), 64'd0);

    // Reset mid-DIVU discards the partial result and clears HI/LO.
    issue(DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);

    run_op("multu_3_5", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
